// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory access controller.
// Size encodings, FSM states, read-latency bounds and store lane helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  // Reserved size counts as misaligned so it never reaches the RAM.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] m;
    case (sz)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] repl_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: selects the addressed byte/halfword lane from the
// RAM word and sign- or zero-extends it to 32 bits.
module load_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sext,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select and extension.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data   = word;
    case (off)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (off[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (size)
      SZ_BYTE: data = {{24{sext & byte_s[7]}}, byte_s};
      SZ_HALF: data = {{16{sext & half_s[15]}}, half_s};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: byte/half/word loads and stores onto a
// word-addressed synchronous RAM, stalling loads for the RAM read latency.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              addr_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int LAT_CLAMP = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                             (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LAT_CLAMP);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZRO = CNT_W'(0);

  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       size_r;
  logic [1:0]       off_r;
  logic             sext_r;
  logic [31:0]      rdata_r;
  logic [31:0]      align_s;
  logic             load_go_s;
  logic             unused_addr_s;

  assign mem_addr      = addr[ADDR_W+1:2];
  assign mem_wdata     = repl_wdata(size, wdata);
  assign rdata         = rdata_r;
  assign unused_addr_s = ^{addr[31:ADDR_W+2]};

  load_align u_align (
    .size (size_r),
    .off  (off_r),
    .sext (sext_r),
    .word (mem_rdata),
    .data (align_s)
  );

  // Next-state and combinational RAM/pipeline controls; reset masks everything.
  always_comb begin
    state_nx_s = state_r;
    stall      = 1'b0;
    addr_err   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 4'b0000;
    load_go_s  = 1'b0;
    if (rst) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (!req) begin
            state_nx_s = IDLE;
          end else if (misaligned(size, addr[1:0])) begin
            addr_err = 1'b1;
          end else if (we) begin
            mem_en = 1'b1;
            mem_we = lane_mask(size, addr[1:0]);
          end else begin
            mem_en     = 1'b1;
            stall      = 1'b1;
            load_go_s  = 1'b1;
            state_nx_s = WAIT;
          end
        end
        WAIT: begin
          stall = 1'b1;
          if (cnt_r == CNT_ONE) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = WAIT;
          end
        end
        // A request seen here belongs to the load that just completed.
        DONE:    state_nx_s = IDLE;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // State, latency counter, latched load attributes and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZRO;
      size_r  <= SZ_BYTE;
      off_r   <= 2'b00;
      sext_r  <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nx_s;
      if (load_go_s) begin
        size_r <= size;
        off_r  <= addr[1:0];
        sext_r <= sign_ext;
        cnt_r  <= LAT_C;
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          rdata_r <= align_s;
        end
      end
    end
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller placed between the pipelined CPU's memory stage and the synchronous data RAM. Converts byte/halfword/word load and store requests into word-addressed RAM accesses with per-lane write enables, and aligns and sign-/zero-extends load data. Stalls the pipeline for the RAM's fixed read latency and flags misaligned accesses without touching memory.

## Interface
- `ADDR_W`, 10: width of the RAM word address `mem_addr`.
- `RD_LAT`, 1: RAM read latency in cycles, from `mem_en` to valid `mem_rdata`; legal range 1..4.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  1  memory-stage access request, valid this cycle.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- `sign_ext`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-justified.
- `rdata`  out  32  aligned, extended load result; valid in the DONE cycle only.
- `stall`  out  1  freeze the pipeline.
- `addr_err`  out  1  misaligned or reserved-size request.
- `mem_en`  out  1  RAM access strobe.
- `mem_we`  out  4  RAM byte-lane write enables; lane k = bits 8k+7:8k.
- `mem_addr`  out  ADDR_W  word address, `addr[ADDR_W+1:2]`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  RAM read data.

## Operation
- Lane mapping is little-endian: the byte at `addr[1:0]`=k occupies lane k.
- Misalignment: half with `addr[0]`=1, word with `addr[1:0]`≠0, or `size`=11.
  - `addr_err`=1 combinationally in the IDLE cycle.
  - `mem_en`=0, `mem_we`=0, `stall`=0; the request is dropped.
- Store (aligned, IDLE):
  - Completes in that cycle with `mem_en`=1 and `stall`=0.
  - `mem_we` is byte 1<<k; half 0011 (`addr[1]`=0) or 1100 (`addr[1]`=1); word 1111.
  - `mem_wdata`: byte replicated ×4, half replicated ×2, word as-is.
- Load: FSM IDLE → WAIT → DONE → IDLE.
  - IDLE with aligned load:
    - `mem_en`=1 and `stall`=1.
    - Latch `size`, `sign_ext` and `addr[1:0]`.
    - Load latency counter with RD_LAT.
    - Go to WAIT.
  - WAIT:
    - `stall`=1, `mem_en`=0; decrement the counter.
    - When the counter reaches 1, register `mem_rdata` and go to DONE.
  - DONE:
    - `stall`=0 and `rdata` valid; always return to IDLE.
    - `req` in DONE belongs to the completed instruction and is ignored.
- Load extraction (latched offset k):
  - Byte: lane k.
  - Half: lanes {1,0} for k=0, lanes {3,2} for k=2.
  - Extend to 32 bits per `sign_ext`.
  - Word: unchanged.
- `rdata` holds its last value outside DONE, and is 0 after reset.
- `req`=0 in IDLE: no outputs asserted.

## Timing
- Reset values: `stall`=0, `addr_err`=0, `mem_en`=0, `mem_we`=0, `rdata`=0, state IDLE, counter 0.
- Load: `stall` is high for RD_LAT+1 cycles (request cycle plus RD_LAT WAIT cycles). `rdata` is valid in the cycle RD_LAT+1 after the request.
- Store: zero stall cycles; the RAM write happens at the request-cycle edge.
- Back-to-back: a new request is accepted in IDLE the cycle after DONE. A store immediately after a load issues in the first IDLE cycle.
- `rst` in WAIT or DONE: next state IDLE, `stall`=0, and the in-flight read data is discarded.
- `rst` has priority over `req` in the same cycle.
- `mem_addr` and `mem_wdata` are combinational from the inputs in IDLE. `mem_addr` is don't-care when `mem_en`=0.

## Structure
- Package `dmem_pkg`:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state enum IDLE/WAIT/DONE;
  - RD_LAT legal bounds.
- Sub-module `load_align`: combinational lane select plus sign/zero extension, fed from the latched size, offset and `sign_ext`.
- Single FSM, counter and result register live in `dmem_ctrl`.

## Test plan
- Store byte 0xA5 to addr 0x0000_0006 → `mem_we`=0100, `mem_addr`=1, `mem_wdata`=0xA5A5A5A5, `stall`=0.
- RAM word 0x8001_7F80; lb at offset 0, signed → `rdata`=0xFFFF_FF80; lbu at offset 1 → 0x0000_007F. `stall` is high exactly RD_LAT+1 cycles for RD_LAT=1 and RD_LAT=3.
- RAM word 0x8001_7F80; lh at offset 2, signed → 0xFFFF_8001; lhu at offset 2 → 0x0000_8001; lw at offset 0 → 0x8001_7F80.
- lw at addr 0x0000_0002 and sh at 0x0000_0003 → `addr_err`=1 for one cycle; `mem_en`=0; `stall`=0; RAM unchanged.
- `rst` raised during WAIT with RD_LAT=3 → `stall`=0 the next cycle, state IDLE; a following load returns correct data.
- Load immediately followed by sw 0x1234_5678 to addr 8 → store issues in the cycle after DONE, `mem_we`=1111, no extra stall.
